// File: rtl/speck_pkg.sv
// Shared SPECK128/128 key-schedule definitions: widths, rotate amounts,
// expansion FSM states and circular rotate helpers.
package speck_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned KEY_W     = 128;
  localparam int unsigned ROT_ALPHA = 8;
  localparam int unsigned ROT_BETA  = 3;
  localparam int unsigned IDX_W     = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRESENT,
    UPDATE,
    DONE
  } state_t;

  function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rol64(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/speck_key_round.sv
// One SPECK128/128 key-schedule step; purely combinational so the encrypt
// datapath can share it.
module speck_key_round
  import speck_pkg::*;
(
  input  logic [WORD_W-1:0] k,
  input  logic [WORD_W-1:0] l,
  input  logic [IDX_W-1:0]  i,
  output logic [WORD_W-1:0] k_next,
  output logic [WORD_W-1:0] l_next
);

  // l' = (ROR8(l) + k) ^ i ; k' = ROL3(k) ^ l'
  always_comb begin
    l_next = (ror64(l, ROT_ALPHA) + k) ^ {{(WORD_W-IDX_W){1'b0}}, i};
    k_next = rol64(k, ROT_BETA) ^ l_next;
  end

endmodule

// File: rtl/speck_key_expand.sv
// SPECK128/128 round-key generator: streams NUM_ROUNDS round keys over a
// valid/ready handshake and reports the final {k, l} for decryption.
module speck_key_expand
  import speck_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              signal_start,
  input  logic [KEY_W-1:0]  key,
  output logic [WORD_W-1:0] rk,
  output logic [IDX_W-1:0]  rk_index,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic              busy,
  output logic              finished,
  output logic [KEY_W-1:0]  final_key
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] k;
  logic [WORD_W-1:0] l;
  logic [IDX_W-1:0]  i;
  logic [WORD_W-1:0] k_next;
  logic [WORD_W-1:0] l_next;

  speck_key_round u_round (
    .k      (k),
    .l      (l),
    .i      (i),
    .k_next (k_next),
    .l_next (l_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    rk_valid   = 1'b0;
    busy       = (state != IDLE);
    rk         = k;
    rk_index   = i;
    unique case (state)
      IDLE:    if (signal_start) state_next = LOAD;
      LOAD:    state_next = PRESENT;
      PRESENT: begin
        rk_valid = 1'b1;
        if (rk_ready) state_next = (i == LAST_IDX) ? DONE : UPDATE;
      end
      UPDATE:  state_next = PRESENT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Key-schedule working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      l <= '0;
      i <= '0;
    end else if (state == LOAD) begin
      k <= key[KEY_W-1:WORD_W];
      l <= key[WORD_W-1:0];
      i <= '0;
    end else if (state == UPDATE) begin
      k <= k_next;
      l <= l_next;
      i <= i + 1'b1;
    end
  end

  // Completion pulse and captured final key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finished  <= 1'b0;
      final_key <= '0;
    end else begin
      finished <= (state == DONE);
      if (state == DONE) final_key <= {k, l};
    end
  end

endmodule

// File: tb/tb_speck_key_expand.sv
// Self-checking bench for speck_key_expand against a behavioural key schedule.
module tb_speck_key_expand;

  localparam int NR = 32;
  localparam logic [127:0] KV = {64'h0706050403020100, 64'h0f0e0d0c0b0a0908};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         signal_start = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] key = '0;
  logic [63:0]  rk;
  logic [5:0]   rk_index;
  logic         rk_valid;
  logic         busy;
  logic         finished;
  logic [127:0] final_key;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_k [0:63];
  logic [63:0] m_l [0:63];
  logic [63:0] got_rk [$];
  logic [5:0]  got_idx [$];
  int          fin_cyc;
  int          stall_errs;
  int          stalls;

  speck_key_expand #(.NUM_ROUNDS(NR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .signal_start (signal_start),
    .key          (key),
    .rk           (rk),
    .rk_index     (rk_index),
    .rk_valid     (rk_valid),
    .rk_ready     (rk_ready),
    .busy         (busy),
    .finished     (finished),
    .final_key    (final_key)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rot_r(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] rot_l(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  task automatic build_model(input logic [127:0] kk);
    m_k[0] = kk[127:64];
    m_l[0] = kk[63:0];
    for (int r = 0; r < 63; r++) begin
      m_l[r+1] = (rot_r(m_l[r], 8) + m_k[r]) ^ 64'(r);
      m_k[r+1] = rot_l(m_k[r], 3) ^ m_l[r+1];
    end
  endtask

  // Starts a run and records every transfer until finished (bounded).
  task automatic run(input logic [127:0] kk, input int ready_pct, input bit hold_start,
                     input int key_change_at, input logic [127:0] kk2);
    bit          held;
    logic [63:0] hrk;
    logic [5:0]  hidx;
    got_rk.delete();
    got_idx.delete();
    fin_cyc = -1;
    stall_errs = 0;
    stalls = 0;
    held = 1'b0;
    hrk = '0;
    hidx = '0;
    key = kk;
    signal_start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) signal_start = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      rk_ready = ($urandom_range(99) < ready_pct);
      if (cyc == key_change_at) key = kk2;
      if (held && !(rk_valid === 1'b1 && rk === hrk && rk_index === hidx)) stall_errs++;
      held = 1'b0;
      if (rk_valid === 1'b1) begin
        if (rk_ready) begin
          got_rk.push_back(rk);
          got_idx.push_back(rk_index);
        end else begin
          held = 1'b1;
          hrk = rk;
          hidx = rk_index;
          stalls++;
        end
      end
      @(posedge clk); #1;
      if (finished === 1'b1) begin
        fin_cyc = cyc;
        break;
      end
    end
    rk_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (rk_valid !== 1'b0) begin failures++; $display("FAIL reset_rk_valid got=%b exp=0", rk_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (finished !== 1'b0) begin failures++; $display("FAIL reset_finished got=%b exp=0", finished); end
    checks++; if (rk !== 64'h0 || rk_index !== 6'h0) begin failures++; $display("FAIL reset_rk got=%h/%0d exp=0/0", rk, rk_index); end
    checks++; if (final_key !== 128'h0) begin failures++; $display("FAIL reset_final_key got=%h exp=0", final_key); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vector();
    run(KV, 100, 1'b0, 0, '0);
    checks++;
    if (got_rk.size() < 2) begin
      failures++; $display("FAIL vector_count got=%0d exp>=2", got_rk.size());
    end else begin
      if (got_rk[0] !== 64'h0706050403020100 || got_idx[0] !== 6'd0) begin
        failures++; $display("FAIL vector_rk0 got=%h/%0d exp=0706050403020100/0", got_rk[0], got_idx[0]);
      end
      checks++;
      if (got_rk[1] !== 64'h37253b31171d0309 || got_idx[1] !== 6'd1) begin
        failures++; $display("FAIL vector_rk1 got=%h/%0d exp=37253b31171d0309/1", got_rk[1], got_idx[1]);
      end
    end
  endtask

  task automatic test_full_run();
    build_model(KV);
    run(KV, 100, 1'b0, 0, '0);
    checks++; if (got_rk.size() != NR) begin failures++; $display("FAIL full_count got=%0d exp=%0d", got_rk.size(), NR); end
    for (int j = 0; j < NR && j < got_rk.size(); j++) begin
      checks++;
      if (got_rk[j] !== m_k[j] || got_idx[j] !== 6'(j)) begin
        failures++; $display("FAIL full_rk%0d got=%h/%0d exp=%h/%0d", j, got_rk[j], got_idx[j], m_k[j], j);
      end
    end
    checks++; if (fin_cyc != 1 + 2*NR) begin failures++; $display("FAIL full_latency got=%0d exp=%0d", fin_cyc, 1 + 2*NR); end
    checks++; if (final_key !== {m_k[NR-1], m_l[NR-1]}) begin failures++; $display("FAIL full_final_key got=%h exp=%h", final_key, {m_k[NR-1], m_l[NR-1]}); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || finished !== 1'b0) begin failures++; $display("FAIL full_after got busy=%b fin=%b exp 0/0", busy, finished); end
  endtask

  task automatic test_backpressure();
    build_model(KV);
    run(KV, 50, 1'b0, 0, '0);
    checks++; if (got_rk.size() != NR || fin_cyc < 0) begin failures++; $display("FAIL bp_count got=%0d fin=%0d exp=%0d", got_rk.size(), fin_cyc, NR); end
    for (int j = 0; j < NR && j < got_rk.size(); j++) begin
      checks++;
      if (got_rk[j] !== m_k[j] || got_idx[j] !== 6'(j)) begin
        failures++; $display("FAIL bp_rk%0d got=%h/%0d exp=%h/%0d", j, got_rk[j], got_idx[j], m_k[j], j);
      end
    end
    checks++; if (stall_errs != 0) begin failures++; $display("FAIL bp_stable got=%0d unstable stalls exp=0", stall_errs); end
    checks++; if (stalls == 0) begin failures++; $display("FAIL bp_stalls got=0 exp>0"); end
  endtask

  task automatic test_random_keys();
    logic [127:0] rkey;
    for (int t = 0; t < 3; t++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      build_model(rkey);
      run(rkey, 70, 1'b0, 0, '0);
      checks++; if (got_rk.size() != NR) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, got_rk.size(), NR); end
      for (int j = 0; j < NR && j < got_rk.size(); j++) begin
        checks++;
        if (got_rk[j] !== m_k[j]) begin failures++; $display("FAIL rand%0d_rk%0d got=%h exp=%h", t, j, got_rk[j], m_k[j]); end
      end
      checks++; if (final_key !== {m_k[NR-1], m_l[NR-1]}) begin failures++; $display("FAIL rand%0d_final got=%h exp=%h", t, final_key, {m_k[NR-1], m_l[NR-1]}); end
    end
  endtask

  // Inverse schedule from final_key walks back to the master key.
  task automatic test_inverse();
    logic [63:0] ck, cl, pk, pl;
    run(KV, 100, 1'b0, 0, '0);
    ck = final_key[127:64];
    cl = final_key[63:0];
    for (int r = NR - 2; r >= 0; r--) begin
      pk = rot_r(ck ^ cl, 3);
      pl = rot_l((cl ^ 64'(r)) - pk, 8);
      ck = pk;
      cl = pl;
      checks++;
      if (r >= got_rk.size() || got_rk[r] !== ck) begin
        failures++; $display("FAIL inv_rk%0d got=%h exp=%h", r, ck, (r < got_rk.size()) ? got_rk[r] : 64'h0);
      end
    end
    checks++; if ({ck, cl} !== KV) begin failures++; $display("FAIL inv_key got=%h exp=%h", {ck, cl}, KV); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    key = KV;
    signal_start = 1'b1;
    @(posedge clk); #1;
    signal_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rk_valid === 1'b1 && rk_index === 6'd10) begin found = 1'b1; break; end
      rk_ready = 1'b1;
      @(posedge clk); #1;
    end
    rk_ready = 1'b0;
    checks++; if (!found) begin failures++; $display("FAIL mid_reach got=none exp=index10"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset got valid=%b busy=%b exp 0/0", rk_valid, busy); end
    checks++; if (rk !== 64'h0 || rk_index !== 6'h0) begin failures++; $display("FAIL mid_reset_rk got=%h/%0d exp=0/0", rk, rk_index); end
    #1 rst_n = 1'b1;
    run(KV, 100, 1'b0, 0, '0);
    checks++;
    if (got_rk.size() < 1 || got_rk[0] !== KV[127:64] || fin_cyc != 1 + 2*NR) begin
      failures++; $display("FAIL mid_restart got size=%0d fin=%0d exp rk0=%h fin=%0d", got_rk.size(), fin_cyc, KV[127:64], 1 + 2*NR);
    end
  endtask

  task automatic test_start_held();
    logic [127:0] kk2;
    kk2 = {$urandom, $urandom, $urandom, $urandom};
    build_model(KV);
    run(KV, 100, 1'b1, 20, kk2);
    checks++; if (got_rk.size() != NR) begin failures++; $display("FAIL held_count got=%0d exp=%0d", got_rk.size(), NR); end
    for (int j = 0; j < NR && j < got_rk.size(); j++) begin
      checks++;
      if (got_rk[j] !== m_k[j]) begin failures++; $display("FAIL held_rk%0d got=%h exp=%h", j, got_rk[j], m_k[j]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_idle got busy=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL held_restart got busy=%b exp=1", busy); end
    @(posedge clk); #1;
    checks++; if (rk_valid !== 1'b1 || rk !== kk2[127:64]) begin failures++; $display("FAIL held_newkey got=%b/%h exp=1/%h", rk_valid, rk, kk2[127:64]); end
    signal_start = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_full_run();
    test_backpressure();
    test_random_keys();
    test_inverse();
    test_reset_mid();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/speck_key_expand.md
SPECK_KEY_EXPAND -- requirements
Module: speck_key_expand

Interface
REQ-001 Parameter NUM_ROUNDS, default 32, SHALL set the number of SPECK128/128 round keys produced (legal range 2..64).
REQ-002 Port clk, input, 1 bit: SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: SHALL be an asynchronous, active-low reset.
REQ-004 Port signal_start, input, 1 bit: SHALL request an expansion; sampled only in IDLE.
REQ-005 Port key, input, 128 bits: SHALL be the master key, with key[127:64] the round-key word k and key[63:0] the l word.
REQ-006 Port rk, output, 64 bits: SHALL be the current round key.
REQ-007 Port rk_index, output, 6 bits: SHALL be the index of rk.
REQ-008 Port rk_valid, output, 1 bit: SHALL flag rk/rk_index as valid.
REQ-009 Port rk_ready, input, 1 bit: SHALL be the consumer accept signal for rk.
REQ-010 Port busy, output, 1 bit: SHALL be high in every state except IDLE.
REQ-011 Port finished, output, 1 bit: SHALL be a one-cycle completion pulse.
REQ-012 Port final_key, output, 128 bits: SHALL be {k, l} after the last update, in the input format of key_schedule_decrypt.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, PRESENT, UPDATE and DONE.
REQ-014 IDLE with signal_start=1 SHALL go to LOAD; with signal_start=0 it SHALL stay in IDLE.
REQ-015 LOAD SHALL register k<=key[127:64], l<=key[63:0] and i<=0, then go to PRESENT.
REQ-016 PRESENT SHALL drive rk_valid=1, rk=k and rk_index=i.
REQ-017 In PRESENT, rk, rk_index and rk_valid SHALL hold stable while rk_ready=0.
REQ-018 A transfer SHALL occur when rk_valid and rk_ready are both high.
REQ-019 On a transfer with i<NUM_ROUNDS-1, the FSM SHALL go to UPDATE.
REQ-020 On a transfer with i=NUM_ROUNDS-1, the FSM SHALL go to DONE.
REQ-021 UPDATE SHALL, in one cycle, compute l' = (ROR8(l) + k) mod 2^64 XOR zero-extended i.
REQ-022 UPDATE SHALL compute k' = ROL3(k) XOR l', register k<=k', l<=l', i<=i+1, and return to PRESENT.
REQ-023 UPDATE SHALL drive rk_valid=0.
REQ-024 Rotates SHALL be true 64-bit circular rotates; the add SHALL be unsigned and wrap modulo 2^64.
REQ-025 DONE SHALL load final_key<={k,l}, pulse finished=1 for exactly one cycle, and go to IDLE.
REQ-026 final_key SHALL hold its value until the next DONE.
REQ-027 Throughput SHALL be one round key per 2 cycles with rk_ready tied high.
REQ-028 With rk_ready tied high, total latency SHALL be 1 + 2*NUM_ROUNDS cycles from the start sample to finished (65 for NUM_ROUNDS=32).
REQ-029 signal_start SHALL be ignored while busy=1; a start asserted in the DONE cycle SHALL be ignored.
REQ-030 The key input SHALL be sampled only in LOAD; later changes to key SHALL NOT affect a run in progress.
REQ-031 rk_ready asserted outside PRESENT SHALL have no effect.

Reset
REQ-032 On rst_n=0, at any time including mid-expansion, the FSM SHALL go to IDLE immediately and asynchronously.
REQ-033 On reset, rk_valid, busy and finished SHALL be 0, and rk, rk_index and final_key SHALL be 0.
REQ-034 On reset, k, l and i SHALL be 0.
REQ-035 The first signal_start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-036 A shared package speck_pkg SHALL hold WORD_W=64, KEY_W=128, ROT_ALPHA=8, ROT_BETA=3, the state enumeration, and the rotate functions ror64/rol64.
REQ-037 The round-update datapath SHALL be one combinational sub-module, speck_key_round (inputs k, l, i; outputs k', l'), reusable by the encrypt datapath.

Verification
REQ-038 Reset, then key={64'h0706050403020100, 64'h0f0e0d0c0b0a0908}, start, rk_ready=1 -> rk0=64'h0706050403020100 (index 0), then rk1=64'h37253b31171d0309 (index 1).
REQ-039 Same key, rk_ready=1 -> 32 transfers with indices 0..31 in order, finished exactly 65 cycles after the start sample, busy low the next cycle.
REQ-040 Random back-pressure on rk_ready (~50%) -> the rk sequence is identical to REQ-039, and rk is stable during every stall.
REQ-041 final_key fed to key_schedule_decrypt repeatedly with round_counter 30 down to 0 -> the recovered round keys match the forward sequence in reverse, ending at key.
REQ-042 rst_n pulsed low during PRESENT of index 10 -> rk_valid=0 and busy=0 immediately; a fresh start then reproduces rk0.
REQ-043 signal_start held high continuously and key changed mid-run -> the run is unaffected, and a new run starts only after IDLE is re-entered.
